// File: rtl/rast_pkg.sv
// rast_pkg
// Shared rasterizer definitions used by the bounding-box scanner and its
// helpers.
//   SYS_BIT_WIDTH  : default width of every pixel coordinate (unsigned)
//   SCREEN_WIDTH   : default horizontal resolution (x is 0..SCREEN_WIDTH-1)
//   SCREEN_HEIGHT  : default vertical resolution (y is 0..SCREEN_HEIGHT-1)
//   scan_state_t   : scanner FSM state encoding
//   vertex_t       : one screen-space vertex {x, y}
package rast_pkg;

  localparam int SYS_BIT_WIDTH = 32;
  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 240;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    EMIT    = 3'd4,
    ADVANCE = 3'd5,
    FINISH  = 3'd6
  } scan_state_t;

  typedef struct packed {
    logic [SYS_BIT_WIDTH-1:0] x;
    logic [SYS_BIT_WIDTH-1:0] y;
  } vertex_t;

endpackage

// File: rtl/tri_bbox_scanner_min3_max3.sv
// min3_max3
// Combinational minimum and maximum of three unsigned values.
//   a, b, c  : operands (W bits, unsigned)
//   min_val  : smallest of a, b, c
//   max_val  : largest of a, b, c
module min3_max3 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] min_val,
  output logic [W-1:0] max_val
);

  logic [W-1:0] min_ab;
  logic [W-1:0] max_ab;

  always_comb begin
    min_ab  = (a < b) ? a : b;
    max_ab  = (a < b) ? b : a;
    min_val = (min_ab < c) ? min_ab : c;
    max_val = (max_ab > c) ? max_ab : c;
  end

endmodule

// File: rtl/tri_bbox_scanner.sv
// tri_bbox_scanner
// Takes one screen-space triangle, computes its bounding box clipped to the
// screen, walks the box in raster order issuing one point query per pixel to
// the point-in-triangle tester, and emits every covered pixel as a fragment.
//
// Ports
//   clk_in, rst_in              : clock, synchronous active-high reset
//   tri_valid_in/tri_ready_out  : triangle handshake
//   vertex_{a,b,c}{x,y}_in      : triangle vertices (captured on accept)
//   vertex_{a,b,c}{x,y}_out     : captured vertices, stable for the triangle
//   test_valid_out              : one-cycle query pulse to the tester
//   test_x_out, test_y_out      : queried pixel, held until the verdict
//   test_done_in/test_inside_in : tester verdict (only sampled in WAIT)
//   frag_valid_out/frag_ready_in: fragment handshake
//   frag_x_out, frag_y_out      : fragment coordinates
//   tri_done_out                : one-cycle pulse once the box is scanned
//   busy_out                    : high whenever the FSM is not IDLE
//   state_out                   : current FSM state (debug)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer raising valid keeps it and its payload stable until
// that transfer; ready may be asserted independently of valid.
module tri_bbox_scanner #(
  parameter int SYS_BIT_WIDTH = rast_pkg::SYS_BIT_WIDTH,
  parameter int SCREEN_WIDTH  = rast_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = rast_pkg::SCREEN_HEIGHT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      tri_valid_in,
  output logic                      tri_ready_out,
  input  logic [SYS_BIT_WIDTH-1:0]  vertex_ax_in,
  input  logic [SYS_BIT_WIDTH-1:0]  vertex_ay_in,
  input  logic [SYS_BIT_WIDTH-1:0]  vertex_bx_in,
  input  logic [SYS_BIT_WIDTH-1:0]  vertex_by_in,
  input  logic [SYS_BIT_WIDTH-1:0]  vertex_cx_in,
  input  logic [SYS_BIT_WIDTH-1:0]  vertex_cy_in,
  output logic [SYS_BIT_WIDTH-1:0]  vertex_ax_out,
  output logic [SYS_BIT_WIDTH-1:0]  vertex_ay_out,
  output logic [SYS_BIT_WIDTH-1:0]  vertex_bx_out,
  output logic [SYS_BIT_WIDTH-1:0]  vertex_by_out,
  output logic [SYS_BIT_WIDTH-1:0]  vertex_cx_out,
  output logic [SYS_BIT_WIDTH-1:0]  vertex_cy_out,
  output logic                      test_valid_out,
  output logic [SYS_BIT_WIDTH-1:0]  test_x_out,
  output logic [SYS_BIT_WIDTH-1:0]  test_y_out,
  input  logic                      test_done_in,
  input  logic                      test_inside_in,
  output logic                      frag_valid_out,
  input  logic                      frag_ready_in,
  output logic [SYS_BIT_WIDTH-1:0]  frag_x_out,
  output logic [SYS_BIT_WIDTH-1:0]  frag_y_out,
  output logic                      tri_done_out,
  output logic                      busy_out,
  output rast_pkg::scan_state_t     state_out
);

  import rast_pkg::*;

  localparam logic [SYS_BIT_WIDTH-1:0] X_LAST = SYS_BIT_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [SYS_BIT_WIDTH-1:0] Y_LAST = SYS_BIT_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [SYS_BIT_WIDTH-1:0] ONE    = SYS_BIT_WIDTH'(1);

  scan_state_t state;

  logic [SYS_BIT_WIDTH-1:0] cur_x, cur_y;
  logic [SYS_BIT_WIDTH-1:0] min_x, max_x, min_y, max_y;

  logic [SYS_BIT_WIDTH-1:0] bb_min_x, bb_max_x, bb_min_y, bb_max_y;
  logic [SYS_BIT_WIDTH-1:0] clip_max_x, clip_max_y;
  logic                     box_empty;

  min3_max3 #(.W(SYS_BIT_WIDTH)) u_mm_x (
    .a       (vertex_ax_out),
    .b       (vertex_bx_out),
    .c       (vertex_cx_out),
    .min_val (bb_min_x),
    .max_val (bb_max_x)
  );

  min3_max3 #(.W(SYS_BIT_WIDTH)) u_mm_y (
    .a       (vertex_ay_out),
    .b       (vertex_by_out),
    .c       (vertex_cy_out),
    .min_val (bb_min_y),
    .max_val (bb_max_y)
  );

  // Only the upper edge needs clipping: coordinates are unsigned, so the lower
  // edge is already on screen. A minimum past the screen edge means the whole
  // box is off screen.
  always_comb begin
    clip_max_x = (bb_max_x > X_LAST) ? X_LAST : bb_max_x;
    clip_max_y = (bb_max_y > Y_LAST) ? Y_LAST : bb_max_y;
    box_empty  = (bb_min_x > X_LAST) || (bb_min_y > Y_LAST);
  end

  // The query and the fragment both describe the pixel under the cursor.
  assign test_x_out = cur_x;
  assign test_y_out = cur_y;
  assign frag_x_out = cur_x;
  assign frag_y_out = cur_y;
  assign state_out  = state;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      tri_ready_out  <= 1'b0;
      test_valid_out <= 1'b0;
      frag_valid_out <= 1'b0;
      tri_done_out   <= 1'b0;
      busy_out       <= 1'b0;
      cur_x          <= '0;
      cur_y          <= '0;
      min_x          <= '0;
      max_x          <= '0;
      min_y          <= '0;
      max_y          <= '0;
      vertex_ax_out  <= '0;
      vertex_ay_out  <= '0;
      vertex_bx_out  <= '0;
      vertex_by_out  <= '0;
      vertex_cx_out  <= '0;
      vertex_cy_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tri_ready_out <= 1'b1;
          if (tri_valid_in && tri_ready_out) begin
            vertex_ax_out <= vertex_ax_in;
            vertex_ay_out <= vertex_ay_in;
            vertex_bx_out <= vertex_bx_in;
            vertex_by_out <= vertex_by_in;
            vertex_cx_out <= vertex_cx_in;
            vertex_cy_out <= vertex_cy_in;
            tri_ready_out <= 1'b0;
            busy_out      <= 1'b1;
            state         <= SETUP;
          end
        end
        SETUP: begin
          min_x <= bb_min_x;
          max_x <= clip_max_x;
          min_y <= bb_min_y;
          max_y <= clip_max_y;
          cur_x <= bb_min_x;
          cur_y <= bb_min_y;
          if (box_empty) begin
            tri_done_out <= 1'b1;
            state        <= FINISH;
          end else begin
            test_valid_out <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          test_valid_out <= 1'b0;
          state          <= WAIT;
        end
        WAIT: begin
          if (test_done_in) begin
            if (test_inside_in) begin
              frag_valid_out <= 1'b1;
              state          <= EMIT;
            end else begin
              state <= ADVANCE;
            end
          end
        end
        EMIT: begin
          if (frag_ready_in) begin
            frag_valid_out <= 1'b0;
            state          <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (cur_x < max_x) begin
            cur_x          <= cur_x + ONE;
            test_valid_out <= 1'b1;
            state          <= ISSUE;
          end else if (cur_y < max_y) begin
            cur_x          <= min_x;
            cur_y          <= cur_y + ONE;
            test_valid_out <= 1'b1;
            state          <= ISSUE;
          end else begin
            tri_done_out <= 1'b1;
            state        <= FINISH;
          end
        end
        FINISH: begin
          tri_done_out  <= 1'b0;
          busy_out      <= 1'b0;
          tri_ready_out <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Bench for tri_bbox_scanner: a tester model with fixed latency, a fragment
// sink, an expected-result model built per triangle, a vector table and a
// few hand-written multi-cycle sequences.
module tb_tri_bbox_scanner;
  import rast_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 3;
  localparam int XL  = 319;
  localparam int YL  = 239;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic         tri_valid_in, tri_ready_out;
  logic [W-1:0] vertex_ax_in, vertex_ay_in, vertex_bx_in, vertex_by_in, vertex_cx_in, vertex_cy_in;
  logic [W-1:0] vertex_ax_out, vertex_ay_out, vertex_bx_out, vertex_by_out, vertex_cx_out, vertex_cy_out;
  logic         test_valid_out, test_done_in, test_inside_in;
  logic [W-1:0] test_x_out, test_y_out;
  logic         frag_valid_out, frag_ready_in;
  logic [W-1:0] frag_x_out, frag_y_out;
  logic         tri_done_out, busy_out;
  scan_state_t  state_out;

  tri_bbox_scanner dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .tri_valid_in   (tri_valid_in),
    .tri_ready_out  (tri_ready_out),
    .vertex_ax_in   (vertex_ax_in),
    .vertex_ay_in   (vertex_ay_in),
    .vertex_bx_in   (vertex_bx_in),
    .vertex_by_in   (vertex_by_in),
    .vertex_cx_in   (vertex_cx_in),
    .vertex_cy_in   (vertex_cy_in),
    .vertex_ax_out  (vertex_ax_out),
    .vertex_ay_out  (vertex_ay_out),
    .vertex_bx_out  (vertex_bx_out),
    .vertex_by_out  (vertex_by_out),
    .vertex_cx_out  (vertex_cx_out),
    .vertex_cy_out  (vertex_cy_out),
    .test_valid_out (test_valid_out),
    .test_x_out     (test_x_out),
    .test_y_out     (test_y_out),
    .test_done_in   (test_done_in),
    .test_inside_in (test_inside_in),
    .frag_valid_out (frag_valid_out),
    .frag_ready_in  (frag_ready_in),
    .frag_x_out     (frag_x_out),
    .frag_y_out     (frag_y_out),
    .tri_done_out   (tri_done_out),
    .busy_out       (busy_out),
    .state_out      (state_out)
  );

  // ---------------- coverage predicate shared by tester and model ----------------
  int pred_mode = 0;

  function automatic logic pred(input int mode, input logic [W-1:0] x, input logic [W-1:0] y);
    if (mode == 0) return ((x + y) <= 32'd4);
    return ((x + y) % 32'd2) == 32'd0;
  endfunction

  // ---------------- tester model: verdict LAT cycles after each query ----------------
  int spur_req = 0;
  int spur_served = 0;
  int tst_cnt = 0;
  logic [W-1:0] tst_x, tst_y;

  initial begin
    test_done_in   = 1'b0;
    test_inside_in = 1'b0;
    forever begin
      @(negedge clk_in);
      test_done_in   = 1'b0;
      test_inside_in = 1'b0;
      if (spur_req != spur_served) begin
        test_done_in   = 1'b1;
        test_inside_in = 1'b1;
        spur_served    = spur_req;
      end else if (tst_cnt == 1) begin
        test_done_in   = 1'b1;
        test_inside_in = pred(pred_mode, tst_x, tst_y);
        tst_cnt        = 0;
      end else if (tst_cnt > 1) begin
        tst_cnt = tst_cnt - 1;
      end
      if (test_valid_out) begin
        tst_x   = test_x_out;
        tst_y   = test_y_out;
        tst_cnt = LAT;
      end
    end
  end

  // ---------------- monitor: records what the DUT produces ----------------
  logic [63:0] obs_q[$];
  logic [63:0] obs_frag_q[$];
  int q_cnt = 0, f_cnt = 0, d_cnt = 0;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (test_valid_out) begin
        obs_q.push_back({test_x_out, test_y_out});
        q_cnt <= q_cnt + 1;
      end
      if (frag_valid_out && frag_ready_in) begin
        obs_frag_q.push_back({frag_x_out, frag_y_out});
        f_cnt <= f_cnt + 1;
      end
      if (tri_done_out) d_cnt <= d_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_frag_q[$];
  int obs_rd = 0, obs_frag_rd = 0;
  int q_base, f_base, d_base;
  int accept_cyc, done_at;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic vertex_t mkv(input int x, input int y);
    vertex_t v;
    v.x = W'(x);
    v.y = W'(y);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Builds the expected query/fragment streams, then offers the triangle.
  // Entered and left on a falling edge; returns at the falling edge of T+1.
  task automatic start_tri(input vertex_t a, input vertex_t b, input vertex_t c, input int mode);
    logic [W-1:0] mnx, mxx, mny, mxy;
    int n;
    mnx = min3(a.x, b.x, c.x);
    mxx = max3(a.x, b.x, c.x);
    mny = min3(a.y, b.y, c.y);
    mxy = max3(a.y, b.y, c.y);
    if (mxx > W'(XL)) mxx = W'(XL);
    if (mxy > W'(YL)) mxy = W'(YL);
    if (mnx <= W'(XL) && mny <= W'(YL)) begin
      for (int yy = int'(mny); yy <= int'(mxy); yy++) begin
        for (int xx = int'(mnx); xx <= int'(mxx); xx++) begin
          exp_q.push_back({W'(xx), W'(yy)});
          if (pred(mode, W'(xx), W'(yy))) exp_frag_q.push_back({W'(xx), W'(yy)});
        end
      end
    end
    pred_mode = mode;
    q_base = q_cnt;
    f_base = f_cnt;
    d_base = d_cnt;
    n = 0;
    while (!tri_ready_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    check("accept_ready", tri_ready_out, 1);
    vertex_ax_in = a.x; vertex_ay_in = a.y;
    vertex_bx_in = b.x; vertex_by_in = b.y;
    vertex_cx_in = c.x; vertex_cy_in = c.y;
    tri_valid_in = 1'b1;
    accept_cyc   = cyc;
    @(posedge clk_in);
    #1 tri_valid_in = 1'b0;
    @(negedge clk_in);
    check("setup_ready_low", tri_ready_out, 0);
    check("setup_busy", busy_out, 1);
    check("setup_state", state_out, SETUP);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!tri_done_out && n < budget);
    check("tri_done_seen", tri_done_out, 1);
    done_at = cyc;
  endtask

  task automatic finish_tri(input int nq, input int nf);
    logic [63:0] e;
    @(negedge clk_in);
    check("ready_after_done", tri_ready_out, 1);
    check("busy_after_done", busy_out, 0);
    check("query_count", 64'(q_cnt - q_base), 64'(nq));
    check("frag_count", 64'(f_cnt - f_base), 64'(nf));
    check("done_count", 64'(d_cnt - d_base), 64'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        check("query_xy", obs_q[obs_rd], e);
        obs_rd++;
      end else begin
        check("query_present", 64'(obs_q.size()), 64'(obs_rd + 1));
      end
    end
    check("query_extra", 64'(obs_q.size() - obs_rd), 64'd0);
    while (exp_frag_q.size() > 0) begin
      e = exp_frag_q.pop_front();
      if (obs_frag_rd < obs_frag_q.size()) begin
        check("frag_xy", obs_frag_q[obs_frag_rd], e);
        obs_frag_rd++;
      end else begin
        check("frag_present", 64'(obs_frag_q.size()), 64'(obs_frag_rd + 1));
      end
    end
    check("frag_extra", 64'(obs_frag_q.size() - obs_frag_rd), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    vertex_t a;
    vertex_t b;
    vertex_t c;
    int      mode;
    int      nq;
    int      nf;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mkvec(input int ax, ay, bx, by, cx, cy, mode, nq, nf);
    vec_t v;
    v.a = mkv(ax, ay);
    v.b = mkv(bx, by);
    v.c = mkv(cx, cy);
    v.mode = mode;
    v.nq = nq;
    v.nf = nf;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    vecs[0] = mkvec(0, 0, 4, 0, 0, 4, 0, 25, 15);
    vecs[1] = mkvec(310, 10, 400, 10, 310, 12, 1, 30, 15);
    vecs[2] = mkvec(500, 10, 400, 20, 330, 5, 0, 0, 0);
    vecs[3] = mkvec(1, 1, 1, 1, 1, 1, 0, 1, 1);
    vecs[4] = mkvec(2, 5, 0, 3, 3, 3, 0, 12, 3);
    vecs[5] = mkvec(5, 240, 6, 300, 7, 250, 1, 0, 0);
    vecs[6] = mkvec(319, 239, 400, 400, 319, 239, 1, 1, 1);

    rst_in        = 1'b1;
    tri_valid_in  = 1'b0;
    frag_ready_in = 1'b1;
    vertex_ax_in = '0; vertex_ay_in = '0; vertex_bx_in = '0;
    vertex_by_in = '0; vertex_cx_in = '0; vertex_cy_in = '0;

    // Reset state.
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_ready", tri_ready_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_state", state_out, IDLE);
    check("rst_test_valid", test_valid_out, 0);
    check("rst_frag_valid", frag_valid_out, 0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    check("idle_ready", tri_ready_out, 1);
    check("idle_state", state_out, IDLE);

    // Spurious verdict while idle.
    @(posedge clk_in);
    #1 spur_req++;
    @(negedge clk_in);
    @(negedge clk_in);
    check("spur_idle_state", state_out, IDLE);
    check("spur_idle_frag", frag_valid_out, 0);
    check("spur_idle_busy", busy_out, 0);

    // Table-driven triangles.
    for (int i = 0; i < 7; i++) begin
      start_tri(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].mode);
      wait_done(2000);
      if (vecs[i].nq == 0) check("empty_done_latency", 64'(done_at - accept_cyc), 64'd2);
      finish_tri(vecs[i].nq, vecs[i].nf);
    end

    // Spurious verdict during ISSUE: single uncovered pixel (6,6).
    start_tri(mkv(6, 6), mkv(6, 6), mkv(6, 6), 0);
    @(posedge clk_in);
    #1 spur_req++;
    @(negedge clk_in);
    check("first_query_t2", test_valid_out, 1);
    check("issue_state", state_out, ISSUE);
    @(negedge clk_in);
    check("spur_issue_state", state_out, WAIT);
    check("spur_issue_frag", frag_valid_out, 0);
    wait_done(500);
    finish_tri(1, 0);

    // Backpressure on the first fragment.
    frag_ready_in = 1'b0;
    start_tri(mkv(0, 0), mkv(4, 0), mkv(0, 4), 0);
    n = 0;
    while (!frag_valid_out && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    check("bp_frag_seen", frag_valid_out, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_frag_held", frag_valid_out, 1);
      check("bp_frag_xy", {frag_x_out, frag_y_out}, {32'd0, 32'd0});
      check("bp_no_query", test_valid_out, 0);
      @(negedge clk_in);
    end
    @(posedge clk_in);
    #1 frag_ready_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    check("bp_resume_advance", state_out, ADVANCE);
    @(negedge clk_in);
    check("bp_next_query", test_valid_out, 1);
    check("bp_next_xy", {test_x_out, test_y_out}, {32'd1, 32'd0});
    wait_done(2000);
    finish_tri(25, 15);

    // Reset while waiting for a verdict; the verdict then arrives late.
    start_tri(mkv(0, 0), mkv(4, 0), mkv(0, 4), 0);
    n = 0;
    while (state_out != WAIT && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    check("pre_rst_wait", state_out, WAIT);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    check("abort_state", state_out, IDLE);
    check("abort_ready", tri_ready_out, 0);
    check("abort_test_valid", test_valid_out, 0);
    check("abort_test_xy", {test_x_out, test_y_out}, 64'd0);
    check("abort_frag_valid", frag_valid_out, 0);
    check("abort_done", tri_done_out, 0);
    check("abort_busy", busy_out, 0);
    check("abort_vertices", 64'(|{vertex_ax_out, vertex_ay_out, vertex_bx_out,
                                   vertex_by_out, vertex_cx_out, vertex_cy_out}), 64'd0);
    @(negedge clk_in);
    check("late_done_state", state_out, IDLE);
    check("late_done_frag", frag_valid_out, 0);
    check("late_done_ready", tri_ready_out, 1);
    exp_q.delete();
    exp_frag_q.delete();
    obs_rd      = obs_q.size();
    obs_frag_rd = obs_frag_q.size();
    start_tri(mkv(1, 1), mkv(1, 1), mkv(1, 1), 0);
    wait_done(500);
    finish_tri(1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tri_bbox_scanner.md
# tri_bbox_scanner

Upstream feeder for the point-in-triangle tester in the 3D rasterizer. Accepts one screen-space triangle at a time and computes its bounding box, clipped to the screen. Walks every pixel of that box in raster order, issuing one point query per pixel to the tester and waiting for its verdict. Emits each covered pixel as a fragment to the downstream shader/framebuffer stage, with backpressure.

## Interface
- SYS_BIT_WIDTH, 32, width of every pixel coordinate (unsigned)
- SCREEN_WIDTH, 320, horizontal resolution; valid x is 0..SCREEN_WIDTH-1
- SCREEN_HEIGHT, 240, vertical resolution; valid y is 0..SCREEN_HEIGHT-1

Ports:
- clk_in  input  1  single clock
- rst_in  input  1  reset, synchronous, active-high
- tri_valid_in  input  1  triangle offered
- tri_ready_out  output  1  scanner can accept a triangle
- vertex_ax/ay/bx/by/cx/cy_in  input  SYS_BIT_WIDTH each  triangle vertices
- vertex_ax/ay/bx/by/cx/cy_out  output  SYS_BIT_WIDTH each  latched vertices to tester, stable for whole triangle
- test_valid_out  output  1  one-cycle query pulse to tester
- test_x_out, test_y_out  output  SYS_BIT_WIDTH  queried pixel
- test_done_in  input  1  tester verdict valid (tester valid_out)
- test_inside_in  input  1  tester verdict (tester is_inside)
- frag_valid_out  output  1  covered pixel available
- frag_ready_in  input  1  downstream accepts fragment
- frag_x_out, frag_y_out  output  SYS_BIT_WIDTH  fragment coordinates
- tri_done_out  output  1  one-cycle pulse, triangle fully scanned
- busy_out  output  1  high in every state except IDLE

## Operation
- States: IDLE, SETUP, ISSUE, WAIT, EMIT, ADVANCE, FINISH.
- IDLE: tri_ready_out=1. On tri_valid_in&&tri_ready_out, latch the vertices and go to SETUP.
- SETUP (1 cycle): compute the box.
  - min_x=min(ax,bx,cx), max_x=min(max(ax,bx,cx), SCREEN_WIDTH-1); likewise for y with SCREEN_HEIGHT.
  - If min_x>SCREEN_WIDTH-1 or min_y>SCREEN_HEIGHT-1, the box is empty: go to FINISH.
  - Otherwise load cur_x=min_x, cur_y=min_y and go to ISSUE.
- ISSUE (1 cycle): test_valid_out=1, test_x_out=cur_x, test_y_out=cur_y. Go to WAIT.
- WAIT: hold test_x/y_out. On test_done_in:
  - if test_inside_in, go to EMIT;
  - else go to ADVANCE.
- EMIT: frag_valid_out=1 with frag_x/y_out=cur_x/cur_y, held stable until frag_ready_in. On the accept cycle, go to ADVANCE.
- ADVANCE (1 cycle):
  - if cur_x<max_x: cur_x++;
  - else if cur_y<max_y: cur_x=min_x, cur_y++;
  - else go to FINISH.
  - If not finishing, go to ISSUE.
- FINISH (1 cycle): tri_done_out=1, then IDLE.
- Comparisons are unsigned, full SYS_BIT_WIDTH. Counters never exceed the clipped max, so there is no wrap-around.
- test_done_in outside WAIT is ignored. At most one query is ever outstanding.
- Degenerate triangles (collinear or coincident vertices) are scanned normally; coverage is the tester's decision.

## Timing
- Reset values: tri_ready_out=0 during reset, 1 from the first cycle after reset deasserts (IDLE). All other outputs are 0. State=IDLE.
- Reset mid-operation aborts the triangle. No tri_done_out is produced, and a pending fragment is dropped.
- Accept at cycle T: SETUP at T+1, first test_valid_out at T+2.
- Per pixel:
  - Uncovered pixel: 1 (ISSUE) + tester latency L + 1 (ADVANCE) cycles. A test_done_in in the cycle after ISSUE is legal.
  - Covered pixel: additionally ≥1 EMIT cycle.
- Empty box: tri_done_out at T+2, tri_ready_out high again at T+3.
- Last pixel: ADVANCE, then FINISH (tri_done_out), then IDLE.
- tri_ready_out is low from T+1 until FINISH completes. A new triangle offered during the scan waits.

## Structure
- Shared package rast_pkg holds:
  - state enum scan_state_t;
  - a vertex struct {x,y} parameterized by SYS_BIT_WIDTH;
  - SCREEN_WIDTH/SCREEN_HEIGHT defaults.
- One sub-module is natural: min3_max3 (combinational min/max of three unsigned values), instanced once for x and once for y.
- The clip logic stays in the top module.

## Test plan
- Triangle (0,0),(4,0),(0,4), bench tester model with L=3 and x+y≤4 inside: exactly 25 test_valid_out pulses in raster order from (0,0) to (4,4); 15 fragments; one tri_done_out.
- Clipping, vertices (310,10),(400,10),(310,12): queries cover x 310..319 and y 10..12 only, 30 pulses; no test_x_out ≥320.
- Off-screen, all x ≥ 320: zero test_valid_out; tri_done_out exactly 2 cycles after accept; tri_ready_out high the cycle after.
- Backpressure: frag_ready_in low for 5 cycles on the first fragment: frag_valid_out and frag_x/y_out held stable, no new test_valid_out; scan resumes the cycle after acceptance.
- Reset asserted in WAIT: next cycle all outputs 0 and state IDLE. A late test_done_in is ignored. A new triangle (1,1),(1,1),(1,1) yields one query at (1,1).
- Spurious test_done_in pulsed in IDLE and in ISSUE: no state change and no fragment.
